// File: rtl/block_loader_mc.sv
// block_loader_mc: fetches an N x N x C tile from a word-addressed memory and
// streams it out in (channel, row, column) order through a small output FIFO.
// Requests are throttled so that every read in flight is guaranteed a FIFO slot.
module block_loader_mc #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned MAX_SIZE   = 32,
  parameter int unsigned MAX_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SZ_W      = $clog2(MAX_SIZE + 1),
  localparam int unsigned CH_W      = $clog2(MAX_CH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_row_stride,
  input  logic [ADDR_W-1:0] i_ch_stride,
  input  logic [SZ_W-1:0]   i_size,
  input  logic [CH_W-1:0]   i_n_ch,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last_row,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  // FIFO entry: {last, last_row, data}
  localparam int unsigned ENT_W = DATA_W + 2;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_done;
  logic   r_err;
  logic   w_done_nxt;
  logic   w_err_nxt;

  // Latched configuration
  logic [ADDR_W-1:0] r_row_stride;
  logic [ADDR_W-1:0] r_ch_stride;
  logic [SZ_W-1:0]   r_size;
  logic [CH_W-1:0]   r_n_ch;

  // Address generator: column/row/channel counters plus running base addresses
  logic [SZ_W-1:0]   r_c;
  logic [SZ_W-1:0]   r_r;
  logic [CH_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_row_addr;
  logic [ADDR_W-1:0] r_ch_addr;

  // Single outstanding read (returns exactly one cycle after its grant)
  logic              r_inflight;
  logic [1:0]        r_pend_tag;

  // Output FIFO
  logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_cfg_ok;
  logic              w_accept;
  logic [CNT_W:0]    w_occ;
  logic              w_room;
  logic              w_fire;
  logic              w_c_end;
  logic              w_r_end;
  logic              w_ch_end;
  logic              w_last_req;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic              w_valid;

  // Configuration checks and handshake decode
  always_comb begin
    w_cfg_ok = (i_size != '0) && (i_size <= SZ_W'(MAX_SIZE)) &&
               (i_n_ch != '0) && (i_n_ch <= CH_W'(MAX_CH));
    w_accept = (r_state == StIdle) && i_start;
    // Occupancy counts the read in flight so its return always finds a slot
    w_occ    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    w_room   = w_occ < (CNT_W + 1)'(FIFO_DEPTH);
    o_mem_req = (r_state == StFetch) && w_room;
    w_fire   = o_mem_req && i_mem_gnt;
    w_c_end  = (r_c == r_size - SZ_W'(1));
    w_r_end  = (r_r == r_size - SZ_W'(1));
    w_ch_end = (r_ch == r_n_ch - CH_W'(1));
    w_last_req = w_c_end && w_r_end && w_ch_end;
    o_mem_addr = r_row_addr + ADDR_W'(r_c);
  end

  // FIFO head and output stream decode; outputs forced to zero while empty
  always_comb begin
    w_head         = r_fifo[r_rptr];
    w_valid        = (r_count != '0);
    // Reads returning with no grant behind them (e.g. across a reset) are dropped
    w_push         = i_mem_rvalid && r_inflight;
    w_pop          = w_valid && i_out_ready;
    o_out_valid    = w_valid;
    o_out_data     = w_valid ? w_head[DATA_W-1:0] : '0;
    o_out_last_row = w_valid && w_head[DATA_W];
    o_out_last     = w_valid && w_head[DATA_W+1];
  end

  // Next-state logic and done/err pulse generation
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_cfg_ok) begin
            w_state_nxt = StFetch;
          end else begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end
        end
      end
      StFetch: begin
        if (w_fire && w_last_req) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && w_head[DATA_W+1]) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State register and status pulses
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Configuration latch and address walk: column fastest, then row, then channel
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_row_stride <= '0;
      r_ch_stride  <= '0;
      r_size       <= '0;
      r_n_ch       <= '0;
      r_c          <= '0;
      r_r          <= '0;
      r_ch         <= '0;
      r_row_addr   <= '0;
      r_ch_addr    <= '0;
    end else if (w_accept && w_cfg_ok) begin
      r_row_stride <= i_row_stride;
      r_ch_stride  <= i_ch_stride;
      r_size       <= i_size;
      r_n_ch       <= i_n_ch;
      r_c          <= '0;
      r_r          <= '0;
      r_ch         <= '0;
      r_row_addr   <= i_base_addr;
      r_ch_addr    <= i_base_addr;
    end else if (w_fire) begin
      if (!w_c_end) begin
        r_c <= r_c + SZ_W'(1);
      end else begin
        r_c <= '0;
        if (!w_r_end) begin
          r_r        <= r_r + SZ_W'(1);
          r_row_addr <= r_row_addr + r_row_stride;
        end else begin
          r_r        <= '0;
          r_ch       <= r_ch + CH_W'(1);
          r_ch_addr  <= r_ch_addr + r_ch_stride;
          r_row_addr <= r_ch_addr + r_ch_stride;
        end
      end
    end
  end

  // Track the outstanding read and the position tags that travel with it
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_inflight <= 1'b0;
      r_pend_tag <= 2'b00;
    end else begin
      r_inflight <= w_fire;
      r_pend_tag <= {w_last_req, w_c_end && w_r_end};
    end
  end

  // FIFO storage; contents need no reset since the count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= {r_pend_tag, i_mem_rdata};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Status outputs
  always_comb begin
    o_busy = (r_state != StIdle);
    o_done = r_done;
    o_err  = r_err;
  end

endmodule

// File: tb/tb_block_loader_mc.sv
// Scoreboard bench for block_loader_mc: a reference model expands each load into
// expected addresses and words; a monitor checks grants, output words and done.
module tb_block_loader_mc;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int MAX_SIZE   = 32;
  localparam int MAX_CH     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int SZ_W       = $clog2(MAX_SIZE + 1);
  localparam int CH_W       = $clog2(MAX_CH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              lr;
    logic              last;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr, i_row_stride, i_ch_stride;
  logic [SZ_W-1:0]   i_size;
  logic [CH_W-1:0]   i_n_ch;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_gnt;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [DATA_W-1:0] o_out_data;
  logic              o_out_valid, i_out_ready, o_out_last_row, o_out_last;
  logic              o_busy, o_done, o_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_grants = 0;
  int n_done   = 0;
  int cyc      = 0;
  int last_pop_cyc = 0;
  int gnt_pct  = 100;
  int rdy_pct  = 100;
  logic exp_err = 1'b0;
  logic pend_rv = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic [ADDR_W-1:0] exp_addr[$];
  word_t             exp_q[$];

  block_loader_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_SIZE(MAX_SIZE),
    .MAX_CH(MAX_CH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_row_stride(i_row_stride), .i_ch_stride(i_ch_stride),
    .i_size(i_size), .i_n_ch(i_n_ch),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_last_row(o_out_last_row), .o_out_last(o_out_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] t;
    t = a * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: every element of the tile, in request order
  task automatic push_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] rs,
                           input logic [ADDR_W-1:0] cs, input int n, input int c);
    logic [31:0] full;
    logic [ADDR_W-1:0] a;
    word_t w;
    for (int ch = 0; ch < c; ch++) begin
      for (int r = 0; r < n; r++) begin
        for (int cc = 0; cc < n; cc++) begin
          full = 32'(base) + 32'(ch) * 32'(cs) + 32'(r) * 32'(rs) + 32'(cc);
          a = full[ADDR_W-1:0];
          exp_addr.push_back(a);
          w.data = mem_word(a);
          w.lr   = (r == n - 1) && (cc == n - 1);
          w.last = w.lr && (ch == c - 1);
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] rs,
                          input logic [ADDR_W-1:0] cs, input logic [SZ_W-1:0] sz,
                          input logic [CH_W-1:0] nch);
    i_base_addr  = base;
    i_row_stride = rs;
    i_ch_stride  = cs;
    i_size       = sz;
    i_n_ch       = nch;
    i_start      = 1'b1;
    @(posedge clk); #1;
    i_start      = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (!o_done && k < maxc) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_seen", {31'd0, o_done}, 32'd1);
    @(posedge clk); #1;
    chk("idle_after_done", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, {31'd0, o_mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, 32'(o_mem_addr), 32'd0);
    chk({tag, "_out_valid"}, {31'd0, o_out_valid}, 32'd0);
    chk({tag, "_out_data"}, 32'(o_out_data), 32'd0);
    chk({tag, "_last_row"}, {31'd0, o_out_last_row}, 32'd0);
    chk({tag, "_last"}, {31'd0, o_out_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory and sink driver: read data returns one cycle after each grant
  initial begin
    i_mem_gnt = 1'b0;
    i_out_ready = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      i_mem_rvalid = pend_rv;
      i_mem_rdata  = pend_rv ? mem_word(pend_addr) : DATA_W'($urandom);
      i_mem_gnt    = ($urandom_range(99) < 32'(gnt_pct));
      i_out_ready  = ($urandom_range(99) < 32'(rdy_pct));
    end
  end

  // Monitor: checks grants, popped words, stall stability and done pulses
  initial begin
    logic        prev_stall;
    logic [31:0] prev_out;
    word_t       e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      pend_rv   = o_mem_req && i_mem_gnt;
      pend_addr = o_mem_addr;
      if (o_mem_req && i_mem_gnt) begin
        n_grants++;
        if (rst_n) begin
          chk("grant_expected", {31'd0, exp_addr.size() != 0}, 32'd1);
          if (exp_addr.size() != 0) chk("mem_addr", 32'(o_mem_addr), 32'(exp_addr.pop_front()));
        end
      end
      if (rst_n && prev_stall)
        chk("stall_hold", {13'd0, o_out_last, o_out_last_row, o_out_data, o_out_valid}, prev_out);
      prev_stall = rst_n && o_out_valid && !i_out_ready;
      prev_out   = {13'd0, o_out_last, o_out_last_row, o_out_data, o_out_valid};
      if (rst_n && o_out_valid && i_out_ready) begin
        chk("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(o_out_data), 32'(e.data));
          chk("out_last_row", {31'd0, o_out_last_row}, {31'd0, e.lr});
          chk("out_last", {31'd0, o_out_last}, {31'd0, e.last});
          if (e.last) last_pop_cyc = cyc;
        end
      end
      if (rst_n && o_done) begin
        n_done++;
        chk("done_err", {31'd0, o_err}, {31'd0, exp_err});
        if (!exp_err) begin
          chk("done_timing", 32'(cyc), 32'(last_pop_cyc + 1));
          chk("scoreboard_empty", 32'(exp_q.size() + exp_addr.size()), 32'd0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, cnt, g0, d0;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_base_addr = '0;
    i_row_stride = '0;
    i_ch_stride = '0;
    i_size = '0;
    i_n_ch = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("post_reset");

    // Basic 3x3x1 tile, full-rate handshakes
    exp_err = 1'b0;
    push_load(16'h0000, 16'd8, 16'd64, 3, 1);
    do_start(16'h0000, 16'd8, 16'd64, SZ_W'(3), CH_W'(1));
    lat = 1;
    while (!o_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_word_latency", 32'(lat), 32'd3);
    cnt = 0;
    repeat (9) begin
      if (o_out_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("sustained_rate", 32'(cnt), 32'd9);
    wait_done(50);

    // Address wrap across 2^ADDR_W, three channels
    push_load(16'hFFFE, 16'd4, 16'd100, 2, 3);
    do_start(16'hFFFE, 16'd4, 16'd100, SZ_W'(2), CH_W'(3));
    wait_done(200);

    // Output back-pressure: requests stop once the FIFO budget is used
    rdy_pct = 0;
    @(posedge clk); #1;
    push_load(16'h1000, 16'd16, 16'h0200, 4, 2);
    g0 = n_grants;
    do_start(16'h1000, 16'd16, 16'h0200, SZ_W'(4), CH_W'(2));
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("stall_grants", 32'(n_grants - g0), 32'(FIFO_DEPTH));
    chk("stall_no_req", {31'd0, o_mem_req}, 32'd0);
    rdy_pct = 100;
    wait_done(300);

    // Illegal configurations
    exp_err = 1'b1;
    g0 = n_grants;
    do_start(16'h0040, 16'd8, 16'd64, SZ_W'(0), CH_W'(1));
    chk("size0_done", {31'd0, o_done}, 32'd1);
    chk("size0_err", {31'd0, o_err}, 32'd1);
    chk("size0_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
    chk("size0_done_pulse", {31'd0, o_done}, 32'd0);
    do_start(16'h0040, 16'd8, 16'd64, SZ_W'(2), CH_W'(MAX_CH + 1));
    chk("nch_done", {31'd0, o_done}, 32'd1);
    chk("nch_err", {31'd0, o_err}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("illegal_no_grants", 32'(n_grants - g0), 32'd0);
    chk("illegal_no_req", {31'd0, o_mem_req}, 32'd0);
    exp_err = 1'b0;

    // Full-size random-handshake load with a start issued while busy
    gnt_pct = 50;
    rdy_pct = 50;
    begin
      logic [ADDR_W-1:0] b, rs, cs;
      b  = ADDR_W'($urandom);
      rs = ADDR_W'($urandom);
      cs = ADDR_W'($urandom);
      push_load(b, rs, cs, MAX_SIZE, MAX_CH);
      d0 = n_done;
      do_start(b, rs, cs, SZ_W'(MAX_SIZE), CH_W'(MAX_CH));
    end
    i_base_addr  = ADDR_W'($urandom);
    i_row_stride = ADDR_W'($urandom);
    i_ch_stride  = ADDR_W'($urandom);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("busy_mid_load", {31'd0, o_busy}, 32'd1);
    do_start(16'h0123, 16'd1, 16'd1, SZ_W'(1), CH_W'(1));
    wait_done(40000);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("done_once", 32'(n_done - d0), 32'd1);
    gnt_pct = 100;
    rdy_pct = 100;

    // Reset in the middle of FETCH, then a clean small load
    push_load(16'h0300, 16'd8, 16'd64, 4, 2);
    do_start(16'h0300, 16'd8, 16'd64, SZ_W'(4), CH_W'(2));
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("busy_before_reset", {31'd0, o_busy}, 32'd1);
    d0 = n_done;
    rst_n = 1'b0;
    exp_q.delete();
    exp_addr.delete();
    @(posedge clk); #1;
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", {31'd0, o_out_valid}, 32'd0);
    chk("release_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
    chk("stale_rvalid_dropped", {31'd0, o_out_valid}, 32'd0);
    push_load(16'h0500, 16'd8, 16'd64, 2, 1);
    do_start(16'h0500, 16'd8, 16'd64, SZ_W'(2), CH_W'(1));
    wait_done(100);
    chk("reset_no_done", 32'(n_done - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_loader_mc.md
BLOCK_LOADER_MC -- requirements
Module: block_loader_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of memory words and output data.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter MAX_SIZE, default 32, largest supported block edge; SZ_W = clog2(MAX_SIZE+1).
REQ-004 SHALL have parameter MAX_CH, default 4, largest channel count; CH_W = clog2(MAX_CH+1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, internal output buffer depth (power of two, >=2).
REQ-006 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have port start  in  1  one-cycle request to begin a load; sampled only when busy=0.
REQ-009 SHALL have ports base_addr  in  ADDR_W, row_stride  in  ADDR_W, ch_stride  in  ADDR_W: tile origin, words per image row, words per channel plane.
REQ-010 SHALL have ports size  in  SZ_W (block edge N) and n_ch  in  CH_W (channel count C).
REQ-011 SHALL have ports mem_req  out  1, mem_addr  out  ADDR_W, mem_gnt  in  1: read request, address, grant.
REQ-012 SHALL have ports mem_rvalid  in  1, mem_rdata  in  DATA_W: read return, exactly one cycle after the granted cycle.
REQ-013 SHALL have ports out_data  out  DATA_W, out_valid  out  1, out_ready  in  1: output stream.
REQ-014 SHALL have ports out_last_row  out  1 (last word of a channel), out_last  out  1 (last word of the load).
REQ-015 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (valid with done).

Function
REQ-016 SHALL latch all configuration inputs on the accepted start cycle; later changes do not affect the load in progress.
REQ-017 SHALL use states IDLE -> FETCH -> DRAIN -> IDLE; busy=1 in FETCH and DRAIN.
REQ-018 SHALL on accepted start with 1<=size<=MAX_SIZE and 1<=n_ch<=MAX_CH enter FETCH next cycle.
REQ-019 SHALL on accepted start with size=0, size>MAX_SIZE, n_ch=0 or n_ch>MAX_CH issue no request, stay IDLE, and pulse done=1, err=1 next cycle.
REQ-020 SHALL address element (ch,r,c) as base_addr + ch*ch_stride + r*row_stride + c, modulo 2^ADDR_W (wrap, no error).
REQ-021 SHALL request in order c fastest, then r, then ch; total N*N*C requests.
REQ-022 SHALL assert mem_req only when FIFO occupancy plus in-flight reads < FIFO_DEPTH; mem_addr held stable until mem_gnt.
REQ-023 SHALL advance to the next address only in a cycle with mem_req=1 and mem_gnt=1; at most one grant per cycle.
REQ-024 SHALL push mem_rdata into the FIFO when mem_rvalid=1; never overflow.
REQ-025 SHALL present the FIFO head on out_data with out_valid=1 while non-empty; pop when out_valid and out_ready.
REQ-026 SHALL hold out_data, out_valid, out_last_row, out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL assert out_last_row with the word (ch, N-1, N-1) and out_last with the word (C-1, N-1, N-1) only.
REQ-028 SHALL move FETCH -> DRAIN in the cycle after the final grant.
REQ-029 SHALL move DRAIN -> IDLE in the cycle after the out_last word is popped, pulsing done=1, err=0 that cycle.
REQ-030 SHALL support simultaneous FIFO push and pop in one cycle, occupancy unchanged.
REQ-031 SHALL ignore start while busy=1; a start in the done cycle is accepted (busy=0).
REQ-032 SHALL give first-word latency of 3 cycles from start (start, FETCH grant, rvalid push, out_valid) with mem_gnt=1, out_ready=1.
REQ-033 SHALL sustain one output word per cycle with mem_gnt=1, out_ready=1 continuously.

Reset
REQ-034 SHALL, while reset=0 at a clock edge, force IDLE, empty FIFO, clear counters and in-flight count.
REQ-035 SHALL drive mem_req=0, out_valid=0, out_last_row=0, out_last=0, busy=0, done=0, err=0, mem_addr=0, out_data=0 during and after reset.
REQ-036 SHALL, on reset mid-load, abandon the load without done; a mem_rvalid arriving the cycle after reset release is discarded.

Verification
REQ-037 SHALL cover: base=0, row_stride=8, ch_stride=64, N=3, C=1, gnt/ready=1 -> addresses 0,1,2,8,9,10,16,17,18; out_last on 9th word; done 1 cycle after.
REQ-038 SHALL cover: N=2, C=3, ch_stride=100, base=0xFFFE, row_stride=4 -> first channel addresses 0xFFFE,0xFFFF,0x0002,0x0003; out_last_row on words 4,8,12.
REQ-039 SHALL cover: N=4, C=2, out_ready=0 for 20 cycles -> exactly FIFO_DEPTH grants then mem_req=0; no data loss; 32 words in order after release.
REQ-040 SHALL cover: start with size=0, and separately n_ch=MAX_CH+1 -> no mem_req; done=1, err=1 next cycle.
REQ-041 SHALL cover: random mem_gnt/out_ready (50%) on N=MAX_SIZE, C=MAX_CH -> output matches reference model, done once, second start ignored while busy.
REQ-042 SHALL cover: reset=0 mid-FETCH -> all outputs 0 next cycle; new start after release completes a clean N=2, C=1 load.
